fb_port_scheduler: RTL

- Clock-domain-PS scheduler that time-shares one single-port frame-buffer BRAM port between two requesters.
- Writer: preprocess output FIFO (pixel ingest). Reader: back-side display CDC FIFO refill.
- Issues round-robin bursts, tracks independent wrapping write/read frame addresses, and flushes the BRAM read pipeline before any turnaround.

---
 rtl/fb_pkg.sv | 8 +
 rtl/fb_addr_ctr.sv | 24 ++
 rtl/fb_port_scheduler.sv | 121 ++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Shared types and frame geometry for the PS-domain frame-buffer port scheduler.
package fb_pkg;
   localparam int FRAME_PIXELS = 307200;
   localparam int ADDR_WIDTH   = 19;

   typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_DRAIN} state_e;
   typedef enum logic       {G_WRITE, G_READ}             grant_e;
endpackage

// File: rtl/fb_addr_ctr.sv
// Modulo-N address counter with synchronous clear and a combinational wrap pulse.
module fb_addr_ctr
   import fb_pkg::*;
#(
   parameter int N = FRAME_PIXELS,
   parameter int W = ADDR_WIDTH
) (
   input  logic         clk_PS,
   input  logic         db_rstn,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt,
   output logic         wrap
);
   localparam logic [W-1:0] LAST = W'(N - 1);

   assign wrap = inc & (cnt == LAST);

   always_ff @(posedge clk_PS or negedge db_rstn) begin
      if (!db_rstn)  cnt <= '0;
      else if (clr)  cnt <= '0;
      else if (inc)  cnt <= wrap ? '0 : cnt + 1'b1;
   end
endmodule

// File: rtl/fb_port_scheduler.sv
// Round-robin time-sharing of one single-port frame-buffer BRAM between pixel
// ingest (writer) and display FIFO refill (reader), with drain before turnaround.
module fb_port_scheduler #(
   parameter int DATA_WIDTH   = 12,
   parameter int FRAME_PIXELS = fb_pkg::FRAME_PIXELS,
   parameter int ADDR_WIDTH   = fb_pkg::ADDR_WIDTH,
   parameter int BURST_LEN    = 16,
   parameter int RD_LATENCY   = 2
) (
   input  logic                  clk_PS,
   input  logic                  db_rstn,
   output logic                  o_src_rd,
   input  logic [DATA_WIDTH-1:0] i_src_data,
   input  logic                  i_src_empty,
   output logic                  o_snk_wr,
   output logic [DATA_WIDTH-1:0] o_snk_wdata,
   input  logic                  i_snk_almostfull,
   input  logic                  i_req,
   input  logic                  i_rd_restart,
   output logic                  o_bram_en,
   output logic                  o_bram_we,
   output logic [ADDR_WIDTH-1:0] o_bram_addr,
   output logic [DATA_WIDTH-1:0] o_bram_wdata,
   input  logic [DATA_WIDTH-1:0] i_bram_rdata,
   output logic                  o_wr_frame,
   output logic                  o_busy
);
   import fb_pkg::*;

   localparam int             BW   = $clog2(BURST_LEN + 1);
   localparam logic [BW-1:0]  BMAX = BW'(BURST_LEN);

   state_e                  state, state_nx;
   grant_e                  last_grant, last_grant_nx;
   logic [BW-1:0]           beat, beat_nx;
   logic                    wr_pend;
   logic [RD_LATENCY-1:0]   vld_pipe;
   logic                    restart_pend;
   logic                    rd_ok, wr_ok, src_rd, rd_issue, drained, drain_exit, rd_clr;
   logic [ADDR_WIDTH-1:0]   wr_addr, rd_addr;
   logic                    wr_wrap, unused_rd_wrap;

   assign rd_ok      = i_req & ~i_snk_almostfull;
   assign wr_ok      = ~i_src_empty;
   assign src_rd     = (state == S_WR) & ~i_src_empty & (beat < BMAX);
   assign rd_issue   = (state == S_RD) & rd_ok & (beat < BMAX);
   assign drained    = ~wr_pend & ~|vld_pipe;
   assign drain_exit = (state == S_DRAIN) & drained;
   // A restart seen during a read burst is held until the port has gone quiet.
   assign rd_clr     = (i_rd_restart & (state != S_RD)) | (restart_pend & drain_exit);

   always_comb begin
      state_nx      = state;
      last_grant_nx = last_grant;
      beat_nx       = beat;
      case (state)
         S_IDLE: begin
            if (rd_ok && (!wr_ok || last_grant == G_WRITE)) begin
               state_nx      = S_RD;
               last_grant_nx = G_READ;
               beat_nx       = '0;
            end else if (wr_ok) begin
               state_nx      = S_WR;
               last_grant_nx = G_WRITE;
               beat_nx       = '0;
            end
         end
         S_WR: begin
            if (src_rd) beat_nx  = beat + 1'b1;
            else        state_nx = S_DRAIN;
         end
         S_RD: begin
            if (rd_issue) beat_nx  = beat + 1'b1;
            else          state_nx = S_DRAIN;
         end
         S_DRAIN: if (drained) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_PS or negedge db_rstn) begin
      if (!db_rstn) begin
         state        <= S_IDLE;
         last_grant   <= G_WRITE;
         beat         <= '0;
         wr_pend      <= 1'b0;
         vld_pipe     <= '0;
         restart_pend <= 1'b0;
      end else begin
         state      <= state_nx;
         last_grant <= last_grant_nx;
         beat       <= beat_nx;
         wr_pend    <= src_rd;
         vld_pipe[0] <= rd_issue;
         for (int i = 1; i < RD_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
         if (drain_exit)                            restart_pend <= 1'b0;
         else if (i_rd_restart && state == S_RD)    restart_pend <= 1'b1;
      end
   end

   fb_addr_ctr #(.N(FRAME_PIXELS), .W(ADDR_WIDTH)) u_wr_ctr (
      .clk_PS (clk_PS), .db_rstn (db_rstn), .inc (wr_pend), .clr (1'b0),
      .cnt (wr_addr), .wrap (wr_wrap)
   );

   fb_addr_ctr #(.N(FRAME_PIXELS), .W(ADDR_WIDTH)) u_rd_ctr (
      .clk_PS (clk_PS), .db_rstn (db_rstn), .inc (rd_issue), .clr (rd_clr),
      .cnt (rd_addr), .wrap (unused_rd_wrap)
   );

   // Write beats and read issues never share a cycle: WR always passes DRAIN before RD.
   assign o_src_rd     = src_rd;
   assign o_bram_en    = wr_pend | rd_issue;
   assign o_bram_we    = wr_pend;
   assign o_bram_addr  = wr_pend ? wr_addr : (rd_issue ? rd_addr : '0);
   assign o_bram_wdata = wr_pend ? i_src_data : '0;
   assign o_snk_wr     = vld_pipe[RD_LATENCY-1];
   assign o_snk_wdata  = o_snk_wr ? i_bram_rdata : '0;
   assign o_wr_frame   = wr_wrap;
   assign o_busy       = (state != S_IDLE);
endmodule
